// File: rtl/maquina_cafe_credito.sv
// Coffee vending controller: selection check, pricing, coin credit, brewing, change.
// Optional VENTAS_CONTADOR_EN adds a saturating 16-bit sales counter output (ventas).
module maquina_cafe_credito #(
  parameter int N_TIPOS     = 4,
  parameter int N_TAMANOS   = 3,
  parameter int MAX_AZUCAR  = 5,
  parameter int CRED_W      = 8,
  parameter int PRECIO_BASE = 2,
  parameter int PASO_TIPO   = 1,
  parameter int PASO_TAMANO = 2,
  parameter int PREP_CICLOS = 2,
  parameter int TIMEOUT     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel_valid,
  input  logic [2:0]        tipo_in,
  input  logic [1:0]        tamano_in,
  input  logic [2:0]        nivel_azucar_in,
  input  logic              moneda_valid,
  input  logic [CRED_W-1:0] moneda_valor,
  input  logic              cancelar,
  output logic [CRED_W-1:0] precio,
  output logic [CRED_W-1:0] credito,
  output logic              sel_error,
  output logic              moneda_rechazo,
  output logic              preparando,
  output logic              concentracion,
  output logic              leche,
  output logic              espuma,
  output logic [2:0]        azucar_anadido,
  output logic              listo,
  output logic [CRED_W-1:0] vuelto,
  output logic              vuelto_valid
`ifdef VENTAS_CONTADOR_EN
  ,
  output logic [15:0]       ventas
`endif
);

  typedef enum logic [2:0] {
    IDLE, VALIDAR, ESPERAR_PAGO, PREPARAR, ENTREGAR, DEVOLVER
  } estado_t;

  estado_t state, state_n;

  logic [2:0]        tipo_q, tipo_n;
  logic [1:0]        tamano_q, tamano_n;
  logic [2:0]        azucar_q, azucar_n;
  logic [15:0]       timer_q, timer_n;
  logic [15:0]       prep_q, prep_n;
  logic [CRED_W-1:0] precio_n, credito_n, vuelto_n;
  logic              sel_error_n, rechazo_n, vuelto_valid_n;
  logic              preparando_n, conc_n, leche_n, espuma_n, listo_n;
  logic [2:0]        azucar_out_n;

  logic [CRED_W:0]   suma;
  logic              sel_ok, coin_ok;
  logic [CRED_W-1:0] precio_calc;
  logic [15:0]       dur, dur_m1;

  always_comb begin
    suma = {1'b0, credito} + {1'b0, moneda_valor};
    sel_ok = (tipo_q >= 3'd1) && (32'(tipo_q) <= N_TIPOS)
          && (tamano_q >= 2'd1) && (32'(tamano_q) <= N_TAMANOS)
          && (32'(azucar_q) <= MAX_AZUCAR);
    precio_calc = CRED_W'(PRECIO_BASE)
                + CRED_W'(tipo_q - 3'd1) * CRED_W'(PASO_TIPO)
                + CRED_W'(tamano_q - 2'd1) * CRED_W'(PASO_TAMANO);
    dur = 16'(tamano_q) * 16'(PREP_CICLOS);
    dur_m1 = (dur == 16'd0) ? 16'd0 : dur - 16'd1;
  end

  always_comb begin
    state_n        = state;
    tipo_n         = tipo_q;
    tamano_n       = tamano_q;
    azucar_n       = azucar_q;
    timer_n        = timer_q;
    prep_n         = prep_q;
    precio_n       = precio;
    credito_n      = credito;
    sel_error_n    = 1'b0;
    rechazo_n      = moneda_valid;
    vuelto_n       = '0;
    vuelto_valid_n = 1'b0;
    coin_ok        = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          tipo_n   = tipo_in;
          tamano_n = tamano_in;
          azucar_n = nivel_azucar_in;
          state_n  = VALIDAR;
        end
      end
      VALIDAR: begin
        if (sel_ok) begin
          precio_n = precio_calc;
          timer_n  = '0;
          state_n  = ESPERAR_PAGO;
        end else begin
          sel_error_n = 1'b1;
          state_n     = IDLE;
        end
      end
      ESPERAR_PAGO: begin
        coin_ok   = moneda_valid && !suma[CRED_W];
        rechazo_n = moneda_valid && !coin_ok;
        if (coin_ok) begin
          credito_n = suma[CRED_W-1:0];
          timer_n   = '0;
        end else begin
          timer_n = timer_q + 16'd1;
        end
        // payment wins over cancel/timeout; a same-cycle coin is refunded
        if (credito_n >= precio) begin
          prep_n  = dur_m1;
          state_n = PREPARAR;
        end else if (cancelar
                  || (!coin_ok && 32'(timer_n) >= TIMEOUT)) begin
          vuelto_n       = credito_n;
          vuelto_valid_n = (credito_n != '0);
          state_n        = DEVOLVER;
        end
      end
      PREPARAR: begin
        if (prep_q == 16'd0) begin
          if (credito > precio) begin
            vuelto_n       = credito - precio;
            vuelto_valid_n = 1'b1;
          end
          state_n = ENTREGAR;
        end else begin
          prep_n = prep_q - 16'd1;
        end
      end
      ENTREGAR, DEVOLVER: begin
        credito_n = '0;
        precio_n  = '0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase

    preparando_n = (state_n == PREPARAR);
    listo_n      = (state_n == ENTREGAR);
    conc_n       = 1'b0;
    leche_n      = 1'b0;
    espuma_n     = 1'b0;
    azucar_out_n = '0;
    if (preparando_n) begin
      azucar_out_n = azucar_n;
      unique case (tipo_n)
        3'd1: ;
        3'd2: leche_n = 1'b1;
        3'd3: conc_n = 1'b1;
        3'd4: {conc_n, leche_n, espuma_n} = 3'b111;
        default: leche_n = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tipo_q         <= '0;
      tamano_q       <= '0;
      azucar_q       <= '0;
      timer_q        <= '0;
      prep_q         <= '0;
      precio         <= '0;
      credito        <= '0;
      sel_error      <= 1'b0;
      moneda_rechazo <= 1'b0;
      preparando     <= 1'b0;
      concentracion  <= 1'b0;
      leche          <= 1'b0;
      espuma         <= 1'b0;
      azucar_anadido <= '0;
      listo          <= 1'b0;
      vuelto         <= '0;
      vuelto_valid   <= 1'b0;
    end else begin
      state          <= state_n;
      tipo_q         <= tipo_n;
      tamano_q       <= tamano_n;
      azucar_q       <= azucar_n;
      timer_q        <= timer_n;
      prep_q         <= prep_n;
      precio         <= precio_n;
      credito        <= credito_n;
      sel_error      <= sel_error_n;
      moneda_rechazo <= rechazo_n;
      preparando     <= preparando_n;
      concentracion  <= conc_n;
      leche          <= leche_n;
      espuma         <= espuma_n;
      azucar_anadido <= azucar_out_n;
      listo          <= listo_n;
      vuelto         <= vuelto_n;
      vuelto_valid   <= vuelto_valid_n;
    end
  end

`ifdef VENTAS_CONTADOR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ventas <= '0;
    else if (state_n == ENTREGAR && ventas != 16'hFFFF)
      ventas <= ventas + 16'd1;
  end
`endif

endmodule

// File: tb/tb_maquina_cafe_credito.sv
// Directed bench for maquina_cafe_credito; second instance uses a 255-unit price.
module tb_maquina_cafe_credito;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel_valid = 1'b0;
  logic [2:0] tipo_in = '0;
  logic [1:0] tamano_in = '0;
  logic [2:0] nivel_azucar_in = '0;
  logic       moneda_valid = 1'b0;
  logic [7:0] moneda_valor = '0;
  logic       cancelar = 1'b0;

  logic [7:0] precio, credito, vuelto;
  logic       sel_error, moneda_rechazo, preparando;
  logic       concentracion, leche, espuma, listo, vuelto_valid;
  logic [2:0] azucar_anadido;

  logic [7:0] b_precio, b_credito, b_vuelto;
  logic       b_sel_error, b_rechazo, b_preparando;
  logic       b_conc, b_leche, b_espuma, b_listo, b_vuelto_valid;
  logic [2:0] b_azucar;
`ifdef VENTAS_CONTADOR_EN
  logic [15:0] ventas, b_ventas;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maquina_cafe_credito u_dut (
    .clk(clk), .reset(reset), .sel_valid(sel_valid),
    .tipo_in(tipo_in), .tamano_in(tamano_in),
    .nivel_azucar_in(nivel_azucar_in),
    .moneda_valid(moneda_valid), .moneda_valor(moneda_valor),
    .cancelar(cancelar), .precio(precio), .credito(credito),
    .sel_error(sel_error), .moneda_rechazo(moneda_rechazo),
    .preparando(preparando), .concentracion(concentracion),
    .leche(leche), .espuma(espuma),
    .azucar_anadido(azucar_anadido), .listo(listo),
    .vuelto(vuelto), .vuelto_valid(vuelto_valid)
`ifdef VENTAS_CONTADOR_EN
    , .ventas(ventas)
`endif
  );

  maquina_cafe_credito #(.PRECIO_BASE(255)) u_big (
    .clk(clk), .reset(reset), .sel_valid(sel_valid),
    .tipo_in(tipo_in), .tamano_in(tamano_in),
    .nivel_azucar_in(nivel_azucar_in),
    .moneda_valid(moneda_valid), .moneda_valor(moneda_valor),
    .cancelar(cancelar), .precio(b_precio), .credito(b_credito),
    .sel_error(b_sel_error), .moneda_rechazo(b_rechazo),
    .preparando(b_preparando), .concentracion(b_conc),
    .leche(b_leche), .espuma(b_espuma),
    .azucar_anadido(b_azucar), .listo(b_listo),
    .vuelto(b_vuelto), .vuelto_valid(b_vuelto_valid)
`ifdef VENTAS_CONTADOR_EN
    , .ventas(b_ventas)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic sel(input int t, input int s, input int a);
    sel_valid = 1'b1;
    tipo_in = 3'(t);
    tamano_in = 2'(s);
    nivel_azucar_in = 3'(a);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic coin(input int v, input logic c);
    moneda_valid = 1'b1;
    moneda_valor = 8'(v);
    cancelar = c;
    tick();
    moneda_valid = 1'b0;
    cancelar = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_precio", 32'(precio), 0);
    chk("rst_credito", 32'(credito), 0);
    chk("rst_prep", 32'(preparando), 0);
    chk("rst_vv", 32'(vuelto_valid), 0);
    reset = 1'b0;
    tick();

    // tipo 1 size 1: exact payment, no change
    sel(1, 1, 2);
    tick();
    chk("t1_precio", 32'(precio), 2);
    coin(2, 1'b0);
    chk("t1_credito", 32'(credito), 2);
    chk("t1_prep", 32'(preparando), 1);
    chk("t1_flags", 32'({concentracion, leche, espuma}), 0);
    chk("t1_azucar", 32'(azucar_anadido), 2);
    tick();
    chk("t1_prep2", 32'(preparando), 1);
    tick();
    chk("t1_prep_end", 32'(preparando), 0);
    chk("t1_listo", 32'(listo), 1);
    chk("t1_vv", 32'(vuelto_valid), 0);
    chk("t1_azu0", 32'(azucar_anadido), 0);
    tick();
    chk("t1_listo_off", 32'(listo), 0);
    chk("t1_clear", 32'(credito), 0);

    // capuchino large, overpay by 3
    sel(4, 3, 0);
    tick();
    chk("t2_precio", 32'(precio), 9);
    coin(4, 1'b0);
    coin(4, 1'b0);
    chk("t2_cred8", 32'(credito), 8);
    chk("t2_wait", 32'(preparando), 0);
    coin(4, 1'b0);
    chk("t2_cred12", 32'(credito), 12);
    chk("t2_flags", 32'({concentracion, leche, espuma}), 7);
    for (int i = 0; i < 6; i++) begin
      chk("t2_prep", 32'(preparando), 1);
      tick();
    end
    chk("t2_listo", 32'(listo), 1);
    chk("t2_vv", 32'(vuelto_valid), 1);
    chk("t2_vuelto", 32'(vuelto), 3);
`ifdef VENTAS_CONTADOR_EN
    chk("t2_ventas", 32'(ventas), 2);
`endif
    tick();
    chk("t2_vv_off", 32'(vuelto_valid), 0);
    chk("t2_precio0", 32'(precio), 0);

    // invalid type
    sel(5, 1, 0);
    tick();
    chk("t3_err", 32'(sel_error), 1);
    chk("t3_precio", 32'(precio), 0);
    tick();
    chk("t3_err_off", 32'(sel_error), 0);

    // timeout refund
    sel(2, 2, 1);
    tick();
    chk("t4_precio", 32'(precio), 5);
    coin(3, 1'b0);
    chk("t4_cred", 32'(credito), 3);
    repeat (9) tick();
    chk("t4_pre_to", 32'(vuelto_valid), 0);
    tick();
    chk("t4_vv", 32'(vuelto_valid), 1);
    chk("t4_vuelto", 32'(vuelto), 3);
    tick();
    chk("t4_clear", 32'(credito), 0);
    coin(1, 1'b0);
    chk("t4_idle_rej", 32'(moneda_rechazo), 1);
    chk("t4_idle_cred", 32'(credito), 0);
    tick();
    chk("t4_rej_off", 32'(moneda_rechazo), 0);

    // cancel with same-cycle coin
    sel(3, 1, 0);
    tick();
    chk("t5_precio", 32'(precio), 4);
    coin(1, 1'b0);
    coin(1, 1'b1);
    chk("t5_vv", 32'(vuelto_valid), 1);
    chk("t5_vuelto", 32'(vuelto), 2);
    chk("t5_prep", 32'(preparando), 0);
    tick();
    chk("t5_clear", 32'(credito), 0);

    // overflow rejection on the 255-price instance, then reset in PREPARAR
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    sel(1, 1, 3);
    tick();
    chk("t6_precio", 32'(b_precio), 255);
    coin(250, 1'b0);
    chk("t6_cred250", 32'(b_credito), 250);
    coin(10, 1'b0);
    chk("t6_rej", 32'(b_rechazo), 1);
    chk("t6_cred_keep", 32'(b_credito), 250);
    coin(5, 1'b0);
    chk("t6_cred255", 32'(b_credito), 255);
    chk("t6_prep", 32'(b_preparando), 1);
    chk("t6_azu", 32'(b_azucar), 3);
    reset = 1'b1;
    tick();
    chk("t6_rst_prep", 32'(b_preparando), 0);
    chk("t6_rst_cred", 32'(b_credito), 0);
    chk("t6_rst_precio", 32'(b_precio), 0);
    chk("t6_rst_azu", 32'(b_azucar), 0);
    chk("t6_rst_vv", 32'(b_vuelto_valid), 0);
    chk("t6_rst_dut", 32'(preparando), 0);
    reset = 1'b0;
    tick();
    chk("t6_after", 32'({b_listo, b_vuelto_valid}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maquina_cafe_credito.md
Name: maquina_cafe_credito

Overview:
Parametrised coffee-vending controller: captures a drink selection, validates it, computes the price, accumulates coin credit, prepares the drink for a size-dependent time and returns change. Generalises the fixed four-drink, single-payment-pulse machine to N drink types, N sizes, configurable sugar range and price/timing constants. Adds multi-coin credit, cancel/refund and change output. Sits between the front-panel/coin-acceptor logic and the brewing actuators.

Parameters:
N_TIPOS, 4, number of drink types; valid tipo_in 1..N_TIPOS
N_TAMANOS, 3, number of sizes; valid tamano_in 1..N_TAMANOS
MAX_AZUCAR, 5, max sugar level; valid nivel_azucar_in 0..MAX_AZUCAR
CRED_W, 8, width of credit/price/change, in units of 250 colones
PRECIO_BASE, 2, price of type 1 size 1 (units)
PASO_TIPO, 1, price increment per type step
PASO_TAMANO, 2, price increment per size step
PREP_CICLOS, 2, preparation cycles per size step
TIMEOUT, 10, idle cycles allowed in ESPERAR_PAGO with no coin

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
sel_valid  in  1  one-cycle strobe: selection inputs valid
tipo_in  in  3  drink type (1 negro, 2 con leche, 3 espresso, 4 capuchino, >4 extra types)
tamano_in  in  2  size
nivel_azucar_in  in  3  sugar level
moneda_valid  in  1  coin strobe
moneda_valor  in  CRED_W  coin value (units)
cancelar  in  1  user cancel request
precio  out  CRED_W  registered price of captured selection
credito  out  CRED_W  accumulated credit
sel_error  out  1  one-cycle pulse: invalid selection
moneda_rechazo  out  1  one-cycle pulse: coin not accepted
preparando  out  1  high in PREPARAR
concentracion, leche, espuma  out  1 each  actuator flags, high only in PREPARAR
azucar_anadido  out  3  captured sugar level during PREPARAR, else 0
listo  out  1  one-cycle pulse in ENTREGAR
vuelto  out  CRED_W  change/refund amount, valid with vuelto_valid
vuelto_valid  out  1  one-cycle pulse

Behaviour:
- Reset: state IDLE; all outputs, credit, timer, prep counter, captured selection = 0.
- All outputs registered (one cycle after state entry).
- IDLE: on sel_valid capture tipo/tamano/azucar -> VALIDAR. sel_valid elsewhere ignored.
- VALIDAR (1 cycle): valid iff 1<=tipo<=N_TIPOS, 1<=tamano<=N_TAMANOS, azucar<=MAX_AZUCAR. Valid: precio = PRECIO_BASE + (tipo-1)*PASO_TIPO + (tamano-1)*PASO_TAMANO (CRED_W, truncating) -> ESPERAR_PAGO. Invalid: sel_error pulse -> IDLE.
- ESPERAR_PAGO: coin adds moneda_valor to credito; timer clears on each accepted coin, else increments. If credito+moneda_valor overflows CRED_W: coin rejected (moneda_rechazo), credit unchanged.
  - credito (including coin this cycle) >= precio -> PREPARAR.
  - cancelar, or timer reaches TIMEOUT with no coin -> DEVOLVER. Coin same cycle as cancel is accepted first and included in refund.
  - Payment completion takes priority over cancel/timeout in the same cycle.
- Coin strobe in any other state -> moneda_rechazo pulse, ignored.
- PREPARAR: lasts tamano*PREP_CICLOS cycles (minimum 1). Flags per type: 1 -> 000, 2 -> 010, 3 -> 100, 4 -> 111, >4 -> 010 {concentracion,leche,espuma}. cancelar ignored. Exit -> ENTREGAR.
- ENTREGAR (1 cycle): listo pulse; if credito>precio: vuelto=credito-precio, vuelto_valid pulse; credito, precio cleared -> IDLE.
- DEVOLVER (1 cycle): vuelto=credito, vuelto_valid pulse only if credito!=0; credito, precio cleared -> IDLE.
- Reset mid-operation: state and credit lost, no refund pulse.

Optional Feature:
VENTAS_CONTADOR_EN: adds output ventas [15:0], incrementing once per ENTREGAR, saturating at 16'hFFFF, cleared by reset. Without the macro the port and counter are absent; behaviour otherwise identical.

Test Plan:
- sel tipo=1 tam=1 azu=2; coin 2 -> precio=2, PREPARAR 2 cycles, flags 000, azucar_anadido=2, listo, no vuelto.
- sel tipo=4 tam=3; coins 4,4,4 -> precio=9, credito 12, PREPARAR 6 cycles, flags 111, vuelto=3 with vuelto_valid.
- sel tipo=5 tam=1 -> sel_error pulse, return to IDLE, no price.
- sel tipo=2 tam=2 (precio=5); coin 3 then no coin for TIMEOUT cycles -> DEVOLVER, vuelto=3; later coin in IDLE -> moneda_rechazo.
- sel tipo=3 tam=1 (precio=4); coin 1 and cancelar same cycle -> vuelto=2 after earlier coin 1; credito cleared.
- credito=250 (CRED_W=8), coin 10 -> moneda_rechazo, credito stays 250; assert reset during PREPARAR -> all outputs 0 next cycle.
